filter_mode_sequencer: RTL and testbench
========================================

// Module: filter_mode_sequencer
// PURPOSE
//  Frame-level controller for the kernel-convolution edge-filter path. Samples the
//  user-requested kernel select and commits it only on a start-of-packet beat, so
//  kernel size never changes mid-frame. Tracks pixel position on the Avalon-ST video
//  stream, flags kernel-border pixels for blanking and detects malformed frames.
//  Sits beside the filter, observing the same stream; drives its kernel-select input.
// PARAMETERS
//  IMG_WIDTH   320  active pixels per line
//  IMG_HEIGHT  240  active lines per frame
//  X_W         9    x_pos width, >= clog2(IMG_WIDTH)
//  Y_W         8    y_pos width, >= clog2(IMG_HEIGHT)
//  CNT_W       16   frame_count width
// PORTS
//  clk               in   1      system clock, all logic on rising edge
//  reset_n           in   1      asynchronous, active-low reset
//  req_flag          in   3      requested kernel: 0 bypass, 1 3x3, 2/3 5x5, 4-7 -> bypass
//  valid_in          in   1      stream valid
//  ready_in          in   1      downstream ready; beat = valid_in & ready_in
//  startofpacket_in  in   1      SOP, qualified by beat
//  endofpacket_in    in   1      EOP, qualified by beat
//  active_flag       out  3      committed kernel select, stable for the whole frame
//  x_pos             out  X_W    column of last accepted beat
//  y_pos             out  Y_W    line of last accepted beat
//  border_blank      out  1      last beat lies within kernel radius of an image edge
//  frame_active      out  1      high while in ACTIVE
//  frame_err         out  1      one-cycle pulse on any framing error
//  frame_count       out  CNT_W  well-formed frames completed, wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; active_flag=0, x_pos=0, y_pos=0,
//    frame_active=0, frame_err=0, frame_count=0. Reset mid-frame discards all state.
//  - All outputs registered except border_blank (combinational from x_pos, y_pos,
//    active_flag). Latency: beat at edge N -> outputs valid after edge N.
//  - Non-beat cycles (valid_in=0 or ready_in=0): no state or counter changes.
//  - States IDLE, ACTIVE, RESYNC:
//    IDLE: beats without SOP ignored. SOP beat -> latch req_flag (4-7 -> 0),
//      x=0, y=0, -> ACTIVE.
//    ACTIVE: each non-SOP beat: x++; at x=IMG_WIDTH-1 wrap x=0, y++.
//      EOP on beat landing at (W-1,H-1): frame_count++, -> IDLE.
//      EOP elsewhere: frame_err, -> IDLE.
//      Beat landing at (W-1,H-1) without EOP: frame_err, -> RESYNC.
//      SOP beat: frame_err, restart as IDLE's SOP path (new flag, x=y=0), stay ACTIVE.
//    RESYNC: ignore beats until EOP beat -> IDLE; SOP beat -> as IDLE's SOP path.
//  - SOP and EOP on the same beat: SOP path taken, then EOP treated as early -> frame_err,
//    -> IDLE (IMG_WIDTH*IMG_HEIGHT > 1 always).
//  - Radius r: flag 0 -> 0, 1 -> 1, 2/3 -> 2. border_blank = frame_active &
//    (x<r | x>IMG_WIDTH-1-r | y<r | y>IMG_HEIGHT-1-r); always 0 for r=0.
//  - req_flag changes between SOPs have no effect on active_flag.
//  - Counters compare against IMG_WIDTH-1 / IMG_HEIGHT-1; y never exceeds IMG_HEIGHT-1.
// STRUCTURE
//  - vfx_pkg: seq_state_t enum {IDLE, ACTIVE, RESYNC}, kernel-flag constants,
//    function flag_radius(flag) -> 2-bit radius, default IMG_WIDTH/IMG_HEIGHT.
//  - Sub-module frame_pos_counter: x/y counter with clear, enable, wrap, and
//    last-pixel flag; FSM, flag latch and error logic stay in the top.
// TESTING
//  - Clean frame, req_flag=1, 76800 beats SOP..EOP -> active_flag=1, frame_count=1,
//    no frame_err, border_blank at (0,5),(319,5),(7,0),(7,239), not at (1,1).
//  - req_flag 1->2 mid-frame -> active_flag stays 1 until next SOP, then 2; border
//    now at (1,1), not at (2,2).
//  - EOP at beat 100 -> one-cycle frame_err, IDLE, frame_count unchanged; next
//    clean frame counts.
//  - 76800 beats without EOP -> frame_err, RESYNC; 10 further beats ignored; EOP -> IDLE.
//  - valid_in toggling and ready_in low stretches -> x/y advance only on beats.
//  - reset_n low at pixel (50,20) -> outputs at reset values same cycle; non-SOP beats
//    ignored until next SOP.

Source files
------------

// File: rtl/vfx_pkg.sv
// Shared types and constants for the video-filter control path.
//   seq_state_t    : frame sequencer states
//   FLAG_*         : kernel-select encodings understood by the filter
//   DEF_IMG_*      : default active image size
//   flag_radius()  : kernel radius (pixels blanked at each edge) for a flag
//   flag_commit()  : maps a requested flag onto a legal one (4-7 -> bypass)
package vfx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESYNC = 2'd2
    } seq_state_t;

    localparam logic [2:0] FLAG_BYPASS  = 3'd0;
    localparam logic [2:0] FLAG_3X3     = 3'd1;
    localparam logic [2:0] FLAG_5X5     = 3'd2;
    localparam logic [2:0] FLAG_5X5_ALT = 3'd3;

    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 240;

    function automatic logic [1:0] flag_radius(input logic [2:0] flag);
        logic [1:0] r;
        case (flag)
            FLAG_3X3:               r = 2'd1;
            FLAG_5X5, FLAG_5X5_ALT: r = 2'd2;
            default:                r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] flag_commit(input logic [2:0] flag);
        return (flag > FLAG_5X5_ALT) ? FLAG_BYPASS : flag;
    endfunction

endpackage

// File: rtl/filter_mode_sequencer_if.sv
// Avalon-ST video stream as observed by the sequencer.
//   valid_in          : source has a pixel on the bus
//   ready_in          : sink accepts this cycle
//   startofpacket_in  : first pixel of a frame
//   endofpacket_in    : last pixel of a frame
// Handshake: a beat happens on a rising clock edge where valid_in and ready_in
// are both high; SOP/EOP are meaningful only on a beat and are ignored otherwise.
interface filter_mode_sequencer_if;
    logic valid_in;
    logic ready_in;
    logic startofpacket_in;
    logic endofpacket_in;

    modport master (
        output valid_in,
        output ready_in,
        output startofpacket_in,
        output endofpacket_in
    );

    modport slave (
        input valid_in,
        input ready_in,
        input startofpacket_in,
        input endofpacket_in
    );
endinterface

// File: rtl/frame_pos_counter.sv
// Pixel position counter for one frame.
//   clk, reset_n  : clock, async active-low reset
//   clr_i         : return to (0,0); wins over en_i
//   en_i          : advance one pixel, wrapping x at the line end
//   x_o, y_o      : current column / line
//   last_next_o   : the next advance lands on the final pixel (W-1,H-1)
// Assumes IMG_WIDTH >= 2.
module frame_pos_counter #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int X_W        = 9,
    parameter int Y_W        = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clr_i,
    input  logic           en_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_next_o
);

    localparam logic [X_W-1:0] X_MAX = X_W'(IMG_WIDTH - 1);
    localparam logic [X_W-1:0] X_PEN = X_W'(IMG_WIDTH - 2);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_HEIGHT - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                // Guard keeps y inside the image even if driven past the end.
                y_d = (y_q == Y_MAX) ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o         = x_q;
    assign y_o         = y_q;
    assign last_next_o = (x_q == X_PEN) && (y_q == Y_MAX);

endmodule

// File: rtl/filter_mode_sequencer.sv
// Frame-level controller for the kernel-convolution edge filter. Commits the
// requested kernel only on start-of-packet, tracks pixel position, flags
// kernel-border pixels and detects malformed frames.
//   clk, reset_n   : clock, async active-low reset
//   st             : observed video stream (slave modport)
//   req_flag       : requested kernel select
//   active_flag    : committed kernel select, constant within a frame
//   x_pos, y_pos   : position of the last accepted beat
//   border_blank   : last beat lies within kernel radius of an edge (combinational)
//   frame_active   : high while a frame is in progress
//   frame_err      : one-cycle pulse on a framing error
//   frame_count    : well-formed frames completed (wraps)
//   state_dbg      : current sequencer state
module filter_mode_sequencer
    import vfx_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int X_W        = 9,
    parameter int Y_W        = 8,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    filter_mode_sequencer_if.slave   st,
    input  logic [2:0]               req_flag,
    output logic [2:0]               active_flag,
    output logic [X_W-1:0]           x_pos,
    output logic [Y_W-1:0]           y_pos,
    output logic                     border_blank,
    output logic                     frame_active,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         frame_count,
    output seq_state_t               state_dbg
);

    seq_state_t       state_q;
    logic [2:0]       active_flag_q;
    logic             frame_active_q;
    logic             frame_err_q;
    logic [CNT_W-1:0] frame_count_q;

    logic beat, sop, eop;
    logic cnt_clr, cnt_en, last_next;

    assign beat = st.valid_in & st.ready_in;
    assign sop  = beat & st.startofpacket_in;
    assign eop  = beat & st.endofpacket_in;

    // Any SOP beat restarts the position; only in-frame non-SOP beats advance it.
    assign cnt_clr = sop;
    assign cnt_en  = beat & ~st.startofpacket_in & (state_q == ACTIVE);

    frame_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .X_W        (X_W),
        .Y_W        (Y_W)
    ) u_pos (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (cnt_clr),
        .en_i        (cnt_en),
        .x_o         (x_pos),
        .y_o         (y_pos),
        .last_next_o (last_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            active_flag_q  <= FLAG_BYPASS;
            frame_active_q <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            frame_err_q <= 1'b0;
            if (sop) begin
                // SOP always starts a frame; inside ACTIVE it also aborts the old one.
                // A simultaneous EOP is a one-pixel frame, which can never be legal.
                active_flag_q <= flag_commit(req_flag);
                if ((state_q == ACTIVE) || eop) begin
                    frame_err_q <= 1'b1;
                end
                if (eop) begin
                    state_q        <= IDLE;
                    frame_active_q <= 1'b0;
                end else begin
                    state_q        <= ACTIVE;
                    frame_active_q <= 1'b1;
                end
            end else if (beat) begin
                case (state_q)
                    ACTIVE: begin
                        if (last_next) begin
                            frame_active_q <= 1'b0;
                            if (eop) begin
                                frame_count_q <= frame_count_q + CNT_W'(1);
                                state_q       <= IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= RESYNC;
                            end
                        end else if (eop) begin
                            frame_err_q    <= 1'b1;
                            frame_active_q <= 1'b0;
                            state_q        <= IDLE;
                        end
                    end
                    RESYNC: begin
                        if (eop) begin
                            state_q <= IDLE;
                        end
                    end
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q        <= IDLE;
                        frame_active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Border test against the committed kernel radius; radius 0 never blanks.
    logic [1:0]     radius;
    logic [X_W-1:0] r_x, x_hi;
    logic [Y_W-1:0] r_y, y_hi;

    assign radius = flag_radius(active_flag_q);
    assign r_x    = X_W'(radius);
    assign r_y    = Y_W'(radius);
    assign x_hi   = X_W'(IMG_WIDTH - 1) - r_x;
    assign y_hi   = Y_W'(IMG_HEIGHT - 1) - r_y;

    assign border_blank = frame_active_q & (radius != 2'd0) &
                          ((x_pos < r_x) | (x_pos > x_hi) |
                           (y_pos < r_y) | (y_pos > y_hi));

    assign active_flag  = active_flag_q;
    assign frame_active = frame_active_q;
    assign frame_err    = frame_err_q;
    assign frame_count  = frame_count_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// Directed bench for filter_mode_sequencer on a reduced 20x10 image.
module tb_filter_mode_sequencer;
    import vfx_pkg::*;

    localparam int W     = 20;
    localparam int H     = 10;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    filter_mode_sequencer_if st_if();

    logic [2:0]       req_flag;
    logic [2:0]       active_flag;
    logic [X_W-1:0]   x_pos;
    logic [Y_W-1:0]   y_pos;
    logic             border_blank;
    logic             frame_active;
    logic             frame_err;
    logic [CNT_W-1:0] frame_count;
    seq_state_t       state_dbg;

    filter_mode_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .X_W        (X_W),
        .Y_W        (Y_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .st           (st_if.slave),
        .req_flag     (req_flag),
        .active_flag  (active_flag),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .border_blank (border_blank),
        .frame_active (frame_active),
        .frame_err    (frame_err),
        .frame_count  (frame_count),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int idx      = 0;   // bench-side pixel index of the last beat in the frame
    logic [CNT_W-1:0] exp_q[$];

    always @(negedge clk) if (frame_err) err_seen++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_count(input string tag);
        logic [CNT_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected-count queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, 32'(frame_count), 32'(e));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_cycle(input logic v, input logic r, input logic s, input logic e);
        st_if.valid_in         = v;
        st_if.ready_in         = r;
        st_if.startofpacket_in = s;
        st_if.endofpacket_in   = e;
        @(posedge clk);
        #1;
        st_if.valid_in         = 1'b0;
        st_if.startofpacket_in = 1'b0;
        st_if.endofpacket_in   = 1'b0;
    endtask

    task automatic send_beat(input logic s, input logic e);
        drive_cycle(1'b1, 1'b1, s, e);
        if (s) idx = 0;
        else   idx++;
    endtask

    task automatic advance_to(input int x, input int y);
        while (idx < y * W + x) send_beat(1'b0, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_pix(input string tag, input int x, input int y, input logic bb);
        advance_to(x, y);
        check_eq({tag, "_x"}, 32'(x_pos), 32'(x));
        check_eq({tag, "_y"}, 32'(y_pos), 32'(y));
        check_eq({tag, "_bb"}, 32'(border_blank), 32'(bb));
    endtask

    // Stall pattern: beats at positions 0,3,6,7,9 -> 5 beats.
    logic [9:0] pat_v = 10'b1011101101;  // bit i = cycle i
    logic [9:0] pat_r = 10'b1111011011;

    initial begin
        st_if.valid_in = 0; st_if.ready_in = 1;
        st_if.startofpacket_in = 0; st_if.endofpacket_in = 0;
        req_flag = 3'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check_eq("rst_flag",  32'(active_flag),  0);
        check_eq("rst_x",     32'(x_pos),        0);
        check_eq("rst_y",     32'(y_pos),        0);
        check_eq("rst_fa",    32'(frame_active), 0);
        check_eq("rst_err",   32'(frame_err),    0);
        check_eq("rst_cnt",   32'(frame_count),  0);
        check_eq("rst_state", 32'(state_dbg),    32'(IDLE));

        // Non-SOP beats in IDLE are ignored
        repeat (3) send_beat(1'b0, 1'b0);
        check_eq("idle_x",  32'(x_pos),        0);
        check_eq("idle_fa", 32'(frame_active), 0);

        // Clean frame with 3x3 kernel, req changes mid-frame
        send_beat(1'b1, 1'b0);
        check_eq("f1_flag", 32'(active_flag),  1);
        check_eq("f1_fa",   32'(frame_active), 1);
        check_eq("f1_bb00", 32'(border_blank), 1);
        check_pix("f1_7_0", 7, 0, 1'b1);
        check_pix("f1_1_1", 1, 1, 1'b0);
        check_pix("f1_0_5", 0, 5, 1'b1);
        req_flag = 3'd2;
        check_pix("f1_19_5", 19, 5, 1'b1);
        check_pix("f1_7_9", 7, 9, 1'b1);
        check_eq("f1_flag_hold", 32'(active_flag), 1);
        advance_to(W - 2, H - 1);
        send_beat(1'b0, 1'b1);
        exp_q.push_back(16'd1);
        check_count("f1_cnt");
        check_eq("f1_err_seen", 32'(err_seen),   0);
        check_eq("f1_end_st",   32'(state_dbg),  32'(IDLE));
        check_eq("f1_end_fa",   32'(frame_active), 0);
        check_eq("f1_end_bb",   32'(border_blank), 0);

        // Next frame commits 5x5
        idle_cycles(2);
        send_beat(1'b1, 1'b0);
        check_eq("f2_flag", 32'(active_flag), 2);
        check_pix("f2_1_1",  1, 1, 1'b1);
        check_pix("f2_2_2",  2, 2, 1'b0);
        check_pix("f2_17_5", 17, 5, 1'b0);
        check_pix("f2_18_5", 18, 5, 1'b1);
        check_pix("f2_5_7",  5, 7, 1'b0);
        check_pix("f2_5_8",  5, 8, 1'b1);
        advance_to(W - 2, H - 1);
        send_beat(1'b0, 1'b1);
        exp_q.push_back(16'd2);
        check_count("f2_cnt");
        check_eq("f2_err_seen", 32'(err_seen), 0);

        // Early EOP on the 100th beat
        req_flag = 3'd1;
        send_beat(1'b1, 1'b0);
        repeat (98) send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        check_eq("early_err",   32'(frame_err), 1);
        check_eq("early_x",     32'(x_pos),     19);
        check_eq("early_y",     32'(y_pos),     4);
        check_eq("early_state", 32'(state_dbg), 32'(IDLE));
        exp_q.push_back(16'd2);
        check_count("early_cnt");
        idle_cycles(1);
        check_eq("early_pulse", 32'(frame_err), 0);
        check_eq("early_seen",  32'(err_seen),  1);
        send_beat(1'b1, 1'b0);
        advance_to(W - 2, H - 1);
        send_beat(1'b0, 1'b1);
        exp_q.push_back(16'd3);
        check_count("f3_cnt");
        check_eq("f3_err_seen", 32'(err_seen), 1);

        // Full frame without EOP -> RESYNC
        send_beat(1'b1, 1'b0);
        advance_to(W - 1, H - 1);
        check_eq("noeop_err",   32'(frame_err),    1);
        check_eq("noeop_state", 32'(state_dbg),    32'(RESYNC));
        check_eq("noeop_fa",    32'(frame_active), 0);
        repeat (10) send_beat(1'b0, 1'b0);
        check_eq("rsy_x",     32'(x_pos),     19);
        check_eq("rsy_y",     32'(y_pos),     9);
        check_eq("rsy_state", 32'(state_dbg), 32'(RESYNC));
        check_eq("rsy_seen",  32'(err_seen),  2);
        send_beat(1'b0, 1'b1);
        check_eq("rsy_exit",  32'(state_dbg), 32'(IDLE));
        check_eq("rsy_err",   32'(frame_err), 0);
        exp_q.push_back(16'd3);
        check_count("rsy_cnt");

        // Stalls: only valid&ready cycles advance
        send_beat(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive_cycle(pat_v[i], pat_r[i], 1'b0, 1'b0);
        check_eq("stall_x", 32'(x_pos), 5);
        check_eq("stall_y", 32'(y_pos), 0);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("stall_sop_x",   32'(x_pos),     5);
        check_eq("stall_sop_err", 32'(frame_err), 0);
        check_eq("stall_state",   32'(state_dbg), 32'(ACTIVE));
        idx = 5;

        // Reset mid-frame at (10,5)
        advance_to(10, 5);
        reset_n = 1'b0;
        #1;
        check_eq("mrst_flag", 32'(active_flag),  0);
        check_eq("mrst_x",    32'(x_pos),        0);
        check_eq("mrst_y",    32'(y_pos),        0);
        check_eq("mrst_fa",   32'(frame_active), 0);
        check_eq("mrst_cnt",  32'(frame_count),  0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        repeat (5) send_beat(1'b0, 1'b0);
        check_eq("mrst_ign_x",  32'(x_pos),     0);
        check_eq("mrst_ign_st", 32'(state_dbg), 32'(IDLE));

        // Flag 3 is a 5x5 kernel; SOP inside a frame restarts with an error
        req_flag = 3'd3;
        send_beat(1'b1, 1'b0);
        check_eq("f3x_flag", 32'(active_flag), 3);
        check_eq("f3x_bb",   32'(border_blank), 1);
        repeat (4) send_beat(1'b0, 1'b0);
        req_flag = 3'd1;
        send_beat(1'b1, 1'b0);
        check_eq("resop_err",   32'(frame_err),   1);
        check_eq("resop_flag",  32'(active_flag), 1);
        check_eq("resop_x",     32'(x_pos),       0);
        check_eq("resop_state", 32'(state_dbg),   32'(ACTIVE));

        // SOP+EOP together with an out-of-range request
        req_flag = 3'd6;
        send_beat(1'b1, 1'b1);
        check_eq("se_flag",  32'(active_flag),  0);
        check_eq("se_err",   32'(frame_err),    1);
        check_eq("se_state", 32'(state_dbg),    32'(IDLE));
        check_eq("se_fa",    32'(frame_active), 0);
        check_eq("se_cnt",   32'(frame_count),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
